if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the RV32IM pipeline: owns the program counter, drives the instruction-memory read port, and registers fetched instructions into the IF/ID pipeline register consumed by the decode stage. It absorbs multi-cycle memory latency, load-use stalls from the hazard unit and taken-branch/jump redirects from EX. On a redirect it emits bubbles (NOP, valid low) so that decode never sees a wrong-path, duplicated or stale instruction.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- STALL  in  1  hazard unit: hold IF/ID contents and freeze PC
- BRANCH_TAKEN  in  1  EX redirect request, single-cycle pulse
- BRANCH_TARGET  in  32  redirect address; bits [1:0] forced to 0
- IMEM_BUSYWAIT  in  1  memory access still in progress
- IMEM_READDATA  in  32  instruction word, valid when READ=1 and BUSYWAIT=0
- IMEM_READ  out  1  read request
- IMEM_ADDRESS  out  32  read address, stable while READ=1 and BUSYWAIT=1
- IF_PC  out  32  PC of registered instruction
- IF_PC_PLUS4  out  32  IF_PC+4
- IF_INSTRUCTION  out  32  registered instruction
- IF_VALID  out  1  IF/ID holds a real instruction

## Operation
- Registers: PC, REDIRECT_PC, SKID (32-bit instruction plus its PC), state, IF/ID register.
- States: FETCH (READ=1, ADDRESS=PC), DISCARD (READ=1, ADDRESS=PC of the abandoned access), HELD (READ=0, instruction sits in SKID).
- Fetch completes in a cycle when state=FETCH and BUSYWAIT=0; on completion PC <= PC+4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
- Priority: RST > BRANCH_TAKEN > STALL > normal.
- FETCH, completion, STALL=0: IF/ID <= {PC, PC+4, READDATA, valid=1}; stay in FETCH.
- FETCH, completion, STALL=1: SKID <= instruction; go to HELD.
- FETCH, no completion, STALL=0: IF/ID <= bubble. STALL=1: IF/ID holds.
- HELD, STALL=0: IF/ID <= SKID; go to FETCH. STALL=1: hold.
- BRANCH_TAKEN in any state: IF/ID <= bubble, even with STALL=1; SKID discarded.
  - Access in flight (FETCH or DISCARD with BUSYWAIT=1): REDIRECT_PC <= target; go to or stay in DISCARD. A second redirect overwrites REDIRECT_PC.
  - Otherwise (completion this cycle, or HELD): PC <= target; go to FETCH; any returned data is dropped.
- DISCARD, BUSYWAIT=0: data dropped; PC <= REDIRECT_PC; go to FETCH. Throughout DISCARD, IF/ID loads bubbles when STALL=0.
- Bubble: IF_INSTRUCTION=32'h0000_0013 (addi x0,x0,0), IF_VALID=0, IF_PC=0, IF_PC_PLUS4=0.

## Timing
- Reset: PC=RESET_PC, state=FETCH, IF/ID=bubble, SKID cleared. IMEM_READ=1 and IMEM_ADDRESS=RESET_PC in the first cycle after RST is released. RST mid-access discards the access.
- Zero-wait memory: the instruction at RESET_PC appears on the IF outputs 1 cycle after the first READ cycle. Sustained throughput is 1 instruction/cycle.
- N-cycle access (BUSYWAIT high N-1 cycles): the instruction appears 1 cycle after BUSYWAIT falls.
- Redirect: the first IF/ID update after BRANCH_TAKEN is a bubble. The target instruction appears earliest 2 cycles after the BRANCH_TAKEN cycle (zero-wait, idle port).
- HELD→FETCH costs one READ-idle cycle.
- IMEM_ADDRESS changes only when READ=0 or in a completion cycle.

## Structure
- Shared package rv32_pkg: NOP_INSTRUCTION constant, if_state_t enum {FETCH, DISCARD, HELD}, XLEN=32.
- One sub-module, if_id_register: IF/ID pipeline register with load, hold and bubble controls. The FSM and PC logic live in the top.

## Test plan
- Reset, zero-wait memory returning addr^32'hA5A5_0000: after RST falls, IF_PC goes 0,4,8 on consecutive cycles with matching IF_INSTRUCTION and IF_VALID=1.
- BUSYWAIT high 3 cycles per access: IF_VALID=0 bubbles during the wait; IF_PC advances by 4 once every 4 cycles; ADDRESS stays stable during each access.
- STALL high 3 cycles while an instruction at 0x10 completes: SKID captures it and IF/ID holds 0x0C; after STALL falls, IF_PC=0x10 and the next fetch is 0x14.
- BRANCH_TAKEN to 0x200 while an access to 0x20 is in flight (BUSYWAIT=1): DISCARD state; the 0x20 data is dropped; bubbles are emitted; the next valid output has IF_PC=0x200.
- Back-to-back redirects to 0x100 then 0x300 during DISCARD: only 0x300 is fetched. BRANCH_TARGET=0x107 fetches 0x104.
- PC at 0xFFFF_FFFC: the next fetch address is 0x0000_0000. RST during HELD: bubble on outputs; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32IM pipeline definitions.
//   XLEN            - datapath width
//   NOP_INSTRUCTION - canonical bubble (addi x0, x0, 0)
//   if_state_t      - fetch-stage FSM states
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTRUCTION = 32'h0000_0013;

    // FETCH   : request outstanding at pc, result goes to IF/ID (or skid)
    // DISCARD : finishing an access that a redirect made obsolete
    // HELD    : instruction parked in the skid buffer, read port idle
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HELD    = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_fetch_stage_if_id_register.sv
// IF/ID pipeline register.
//   clk, rst      - clock, synchronous active-high reset (loads a bubble)
//   load          - capture pc / pc_plus4 / instruction as a valid entry
//   bubble        - load a NOP with valid low (wins over load)
//   pc, pc_plus4, instruction - incoming entry
//   if_*          - registered entry seen by decode
// With neither load nor bubble asserted the register holds.
module if_id_register
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [XLEN-1:0] if_instruction,
    output logic            if_valid
);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_plus4_reg;
    logic [XLEN-1:0] instruction_reg;
    logic            valid_reg;

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            pc_reg          <= '0;
            pc_plus4_reg    <= '0;
            instruction_reg <= NOP_INSTRUCTION;
            valid_reg       <= 1'b0;
        end else if (load) begin
            pc_reg          <= pc;
            pc_plus4_reg    <= pc_plus4;
            instruction_reg <= instruction;
            valid_reg       <= 1'b1;
        end
    end

    assign if_pc          = pc_reg;
    assign if_pc_plus4    = pc_plus4_reg;
    assign if_instruction = instruction_reg;
    assign if_valid       = valid_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory read port,
// skid buffer for stalls and redirect handling, feeding the IF/ID register.
//   clk, rst       - clock, synchronous active-high reset
//   stall          - hold IF/ID and freeze the PC
//   branch_taken   - single-cycle redirect request from EX
//   branch_target  - redirect address (low two bits ignored)
//   imem_busywait  - memory access still in progress
//   imem_readdata  - instruction word returned by memory
//   imem_read      - read request
//   imem_address   - read address
//   if_pc, if_pc_plus4, if_instruction, if_valid - IF/ID contents
module if_fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            imem_busywait,
    input  logic [XLEN-1:0] imem_readdata,
    output logic            imem_read,
    output logic [XLEN-1:0] imem_address,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [XLEN-1:0] if_instruction,
    output logic            if_valid
);

    if_state_t       state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;
    logic [XLEN-1:0] skid_instr_reg, skid_instr_next;
    logic [XLEN-1:0] skid_pc_reg, skid_pc_next;

    logic            ifid_load;
    logic            ifid_bubble;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;
    logic            access_in_flight;

    assign pc_plus4         = pc_reg + 32'd4;
    assign target_aligned   = branch_target & ~32'h3;
    // A request is outstanding in FETCH and DISCARD; it is still running
    // while busywait is high and must be allowed to finish undisturbed.
    assign access_in_flight = (state_reg != HELD) && imem_busywait;

    // The PC is never touched while an access is running (a redirect goes
    // to redirect_pc instead), so the address stays stable until completion.
    assign imem_read    = (state_reg != HELD);
    assign imem_address = pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            redirect_pc_reg <= RESET_PC;
            skid_instr_reg  <= NOP_INSTRUCTION;
            skid_pc_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            redirect_pc_reg <= redirect_pc_next;
            skid_instr_reg  <= skid_instr_next;
            skid_pc_reg     <= skid_pc_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        redirect_pc_next = redirect_pc_reg;
        skid_instr_next  = skid_instr_reg;
        skid_pc_next     = skid_pc_reg;
        ifid_load        = 1'b0;
        ifid_bubble      = 1'b0;
        ifid_pc          = pc_reg;
        ifid_instr       = imem_readdata;

        if (branch_taken) begin
            // Wrong-path work is thrown away even under stall.
            ifid_bubble     = 1'b1;
            skid_instr_next = NOP_INSTRUCTION;
            skid_pc_next    = '0;
            if (access_in_flight) begin
                redirect_pc_next = target_aligned;
                state_next       = DISCARD;
            end else begin
                pc_next    = target_aligned;
                state_next = FETCH;
            end
        end else begin
            unique case (state_reg)
                FETCH: begin
                    if (!imem_busywait) begin
                        pc_next = pc_plus4;
                        if (stall) begin
                            skid_instr_next = imem_readdata;
                            skid_pc_next    = pc_reg;
                            state_next      = HELD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
                DISCARD: begin
                    if (!stall) begin
                        ifid_bubble = 1'b1;
                    end
                    if (!imem_busywait) begin
                        pc_next    = redirect_pc_reg;
                        state_next = FETCH;
                    end
                end
                HELD: begin
                    if (!stall) begin
                        ifid_load  = 1'b1;
                        ifid_pc    = skid_pc_reg;
                        ifid_instr = skid_instr_reg;
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    if_id_register u_if_id_register (
        .clk            (clk),
        .rst            (rst),
        .load           (ifid_load),
        .bubble         (ifid_bubble),
        .pc             (ifid_pc),
        .pc_plus4       (ifid_pc + 32'd4),
        .instruction    (ifid_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instruction (if_instruction),
        .if_valid       (if_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. Memory returns addr ^ 32'hA5A5_0000
// after a programmable number of busywait cycles per access.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_busywait;
    logic [31:0] imem_readdata;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instruction;
    logic        if_valid;

    int n_checks = 0;
    int n_fail   = 0;

    int wait_cycles = 0;
    int busy_cnt    = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_busywait  (imem_busywait),
        .imem_readdata  (imem_readdata),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instruction (if_instruction),
        .if_valid       (if_valid)
    );

    // Memory model: busy for wait_cycles cycles of each read, then done.
    always @(posedge clk) begin
        if (rst || !imem_read)          busy_cnt <= 0;
        else if (busy_cnt >= wait_cycles) busy_cnt <= 0;
        else                            busy_cnt <= busy_cnt + 1;
    end
    assign imem_busywait = imem_read && (busy_cnt < wait_cycles);
    assign imem_readdata = imem_address ^ 32'hA5A5_0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_valid(input string tag, input logic [31:0] pc);
        check_eq({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
        check_eq({tag, ".pc"}, if_pc, pc);
        check_eq({tag, ".pc4"}, if_pc_plus4, pc + 32'd4);
        check_eq({tag, ".instr"}, if_instruction, pc ^ 32'hA5A5_0000);
    endtask

    task automatic expect_bubble(input string tag);
        check_eq({tag, ".valid"}, {31'd0, if_valid}, 32'd0);
        check_eq({tag, ".pc"}, if_pc, 32'd0);
        check_eq({tag, ".pc4"}, if_pc_plus4, 32'd0);
        check_eq({tag, ".instr"}, if_instruction, 32'h0000_0013);
    endtask

    task automatic expect_port(input string tag, input logic rd, input logic [31:0] addr);
        check_eq({tag, ".read"}, {31'd0, imem_read}, {31'd0, rd});
        if (rd) check_eq({tag, ".addr"}, imem_address, addr);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        wait_cycles = 0;

        // Reset state
        step(); step();
        expect_bubble("reset");
        rst = 1'b0;
        expect_port("first_read", 1'b1, 32'h0);

        // Zero-wait streaming
        step(); expect_valid("zw0", 32'h0); expect_port("zw0", 1'b1, 32'h4);
        step(); expect_valid("zw4", 32'h4);
        step(); expect_valid("zw8", 32'h8); expect_port("zw8", 1'b1, 32'hC);

        // Three busywait cycles per access: bubbles, stable address
        wait_cycles = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_bubble($sformatf("wait_c%0d", i));
            expect_port($sformatf("wait_c%0d", i), 1'b1, 32'hC);
        end
        step(); expect_valid("wait_done", 32'hC); expect_port("wait_done", 1'b1, 32'h10);

        // Stall across completion of 0x10 (two wait cycles, then done)
        wait_cycles = 2;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_valid($sformatf("stall_c%0d", i), 32'hC);
        end
        expect_port("held", 1'b0, 32'h0);
        stall = 1'b0;
        wait_cycles = 0;
        step(); expect_valid("unstall", 32'h10); expect_port("unstall", 1'b1, 32'h14);
        step(); expect_valid("after_stall", 32'h14);
        step(); expect_valid("s18", 32'h18);
        step(); expect_valid("s1c", 32'h1C); expect_port("s1c", 1'b1, 32'h20);

        // Redirect to 0x200 while 0x20 is in flight
        wait_cycles = 3;
        branch_taken = 1'b1; branch_target = 32'h200;
        step(); expect_bubble("br_c0"); expect_port("br_c0", 1'b1, 32'h20);
        branch_taken = 1'b0;
        step(); expect_bubble("br_c1"); expect_port("br_c1", 1'b1, 32'h20);
        step(); expect_bubble("br_c2"); expect_port("br_c2", 1'b1, 32'h20);
        step(); expect_bubble("br_c3"); expect_port("br_c3", 1'b1, 32'h200);
        wait_cycles = 0;
        step(); expect_valid("br_tgt", 32'h200); expect_port("br_tgt", 1'b1, 32'h204);

        // Back-to-back redirects during DISCARD: only 0x300 survives
        wait_cycles = 3;
        branch_taken = 1'b1; branch_target = 32'h100;
        step(); expect_bubble("b2b_c0"); expect_port("b2b_c0", 1'b1, 32'h204);
        branch_target = 32'h300;
        step(); expect_bubble("b2b_c1"); expect_port("b2b_c1", 1'b1, 32'h204);
        branch_taken = 1'b0;
        step(); expect_bubble("b2b_c2");
        step(); expect_bubble("b2b_c3"); expect_port("b2b_c3", 1'b1, 32'h300);
        wait_cycles = 0;
        step(); expect_valid("b2b_tgt", 32'h300);

        // Misaligned target: low bits cleared; redirect at completion
        branch_taken = 1'b1; branch_target = 32'h107;
        step(); expect_bubble("mis_c0"); expect_port("mis_c0", 1'b1, 32'h104);
        branch_taken = 1'b0;
        step(); expect_valid("mis_tgt", 32'h104);

        // PC wrap from 0xFFFF_FFFC
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step(); expect_bubble("wrap_c0"); expect_port("wrap_c0", 1'b1, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        step(); expect_valid("wrap_top", 32'hFFFF_FFFC); expect_port("wrap_top", 1'b1, 32'h0);
        step(); expect_valid("wrap_zero", 32'h0);

        // Reset during HELD
        stall = 1'b1;
        step(); expect_valid("hold_pre", 32'h0); expect_port("hold_pre", 1'b0, 32'h0);
        rst = 1'b1;
        step(); expect_bubble("rst_held");
        rst = 1'b0; stall = 1'b0;
        expect_port("rst_restart", 1'b1, 32'h0);
        step(); expect_valid("rst_f0", 32'h0);
        step(); expect_valid("rst_f4", 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
